// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one multiplier bit or quotient bit per cycle.
// Holds the pipeline stall while busy and pulses done for one cycle with the result.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [2:0]         op_reg;
    logic               neg_reg;
    logic [WIDTH-1:0]   mag_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   result_reg;

    // ------------------------------------------------------------------
    // Operand decode at accept time
    // ------------------------------------------------------------------
    logic             a_signed, b_signed, a_neg, b_neg;
    logic             is_div, is_rem, div_zero, div_ovf, special;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;
    logic             neg_sel;
    logic             idle_or_done, busy, accept, iterate, last_iter;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg   = a_signed & a[WIDTH-1];
    assign b_neg   = b_signed & b[WIDTH-1];
    assign mag_a   = a_neg ? (~a + 1'b1) : a;
    assign mag_b   = b_neg ? (~b + 1'b1) : b;
    assign is_div  = funct3[2];
    assign is_rem  = funct3[2] & funct3[1];
    // Remainder follows the dividend; product and quotient follow the operand sign xor
    assign neg_sel = is_rem ? a_neg : (a_neg ^ b_neg);

    assign div_zero = is_div && (b == '0);
    assign div_ovf  = is_div && !funct3[0] && !div_zero &&
                      (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = is_rem ? a : '1;
        else if (div_ovf)
            special_res = is_rem ? '0 : a;
    end

    assign idle_or_done = (state_reg == S_IDLE) || (state_reg == S_DONE);
    assign busy         = (state_reg == S_MUL) || (state_reg == S_DIV);
    assign accept       = idle_or_done & start & ~flush;
    assign iterate      = busy & ~flush;
    assign last_iter    = (cnt_reg == CW'(WIDTH-1));

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step, mul_fin;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   div_rem_new;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   quo_fin, rem_fin;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                   (acc_reg[0] ? {1'b0, mag_reg} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, acc_reg[WIDTH-1:1]};
        mul_fin  = neg_reg ? (~mul_step + 1'b1) : mul_step;

        // High half holds the partial remainder, low half shifts the dividend out
        div_shift   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_diff    = div_shift - {1'b0, mag_reg};
        q_bit       = ~div_diff[WIDTH];
        div_rem_new = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_step    = {div_rem_new, acc_reg[WIDTH-2:0], q_bit};
        quo_fin     = neg_reg ? (~div_step[WIDTH-1:0] + 1'b1) : div_step[WIDTH-1:0];
        rem_fin     = neg_reg ? (~div_step[2*WIDTH-1:WIDTH] + 1'b1)
                              : div_step[2*WIDTH-1:WIDTH];

        final_res = '0;
        if (state_reg == S_MUL)
            final_res = (op_reg == 3'd0) ? mul_fin[WIDTH-1:0] : mul_fin[2*WIDTH-1:WIDTH];
        else
            final_res = op_reg[1] ? rem_fin : quo_fin;
    end

    // ------------------------------------------------------------------
    // FSM: state register, next-state, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start)
                        state_next = special ? S_DONE : (is_div ? S_DIV : S_MUL);
                    else
                        state_next = S_IDLE;
                end
                S_MUL, S_DIV: begin
                    if (last_iter)
                        state_next = S_DONE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall  = rst & (accept | busy);
        done   = (state_reg == S_DONE);
        result = result_reg;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            mag_reg    <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
            op_reg  <= funct3;
            neg_reg <= neg_sel;
            if (special) begin
                acc_reg    <= '0;
                mag_reg    <= '0;
                result_reg <= special_res;
            end else if (is_div) begin
                acc_reg <= {{WIDTH{1'b0}}, mag_a};
                mag_reg <= mag_b;
            end else begin
                acc_reg <= {{WIDTH{1'b0}}, mag_b};
                mag_reg <= mag_a;
            end
        end else if (iterate) begin
            acc_reg <= (state_reg == S_MUL) ? mul_step : div_step;
            if (last_iter)
                result_reg <= final_res;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, special cases, back-to-back, flush, reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result = 32'h0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
        @(negedge clk);
        rst = 1'b1;
        $display("reset: stall=%b done=%b result=%h", stall, done, result);
    endtask

    // Issue one operation and follow it until exp_done+2 cycles after accept
    task automatic do_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input int exp_done, input string name);
        int          done_cyc;
        int          done_cnt;
        int          bad_stall;
        logic [31:0] res_at_done;
        done_cyc = -1; done_cnt = 0; bad_stall = -1; res_at_done = 'x;
        @(negedge clk);
        start = 1'b1; funct3 = f3; a = av; b = bv;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_c0: got %b expected 1", name, stall); end
        for (int c = 1; c <= exp_done + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; res_at_done = result; end
            end
            if ((stall !== (c < exp_done)) && bad_stall < 0) bad_stall = c;
        end
        n_checks++;
        if (done_cyc != exp_done) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc, exp_done); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt); end
        n_checks++;
        if (bad_stall >= 0) begin n_fail++; $display("FAIL %s_stall: wrong stall in cycle %0d expected high through cycle %0d", name, bad_stall, exp_done - 1); end
        n_checks++;
        if (res_at_done !== exp_res) begin n_fail++; $display("FAIL %s_result: got %h expected %h", name, res_at_done, exp_res); end
        last_result = exp_res;
        $display("%s: a=%h b=%h result=%h done_cycle=%0d", name, av, bv, res_at_done, done_cyc);
    endtask

    task automatic test_mul();
        do_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3");
        do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
    endtask

    task automatic test_div();
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_m7_2");
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_m7_2");
        do_op(3'd5, 32'd100,      32'd7, 32'd14,       33, "divu_100_7");
        do_op(3'd7, 32'd100,      32'd7, 32'd2,        33, "remu_100_7");
    endtask

    task automatic test_special();
        do_op(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_by_zero");
        do_op(3'd6, 32'd5,        32'd0,        32'd5,        1, "rem_by_zero");
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_overflow");
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_overflow");
    endtask

    task automatic test_back_to_back();
        int          done2_cyc;
        int          bad_stall;
        logic [31:0] res2;
        logic [31:0] held;
        done2_cyc = -1; bad_stall = -1; res2 = 'x; held = 'x;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd4;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 33) begin
                start = 1'b1; funct3 = 3'd5; a = 32'd9; b = 32'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            if (c == 33) begin
                n_checks++;
                if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", done); end
                n_checks++;
                if (result !== 32'd12) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 0000000c", result); end
            end
            if (c == 50) held = result;
            if (c > 33 && done === 1'b1 && done2_cyc < 0) begin done2_cyc = c; res2 = result; end
            if ((stall !== (c < 66)) && bad_stall < 0) bad_stall = c;
        end
        n_checks++;
        if (bad_stall >= 0) begin n_fail++; $display("FAIL b2b_stall: wrong stall in cycle %0d", bad_stall); end
        n_checks++;
        if (held !== 32'd12) begin n_fail++; $display("FAIL b2b_result_held: got %h expected 0000000c", held); end
        n_checks++;
        if (done2_cyc != 66) begin n_fail++; $display("FAIL b2b_second_done_cycle: got %0d expected 66", done2_cyc); end
        n_checks++;
        if (res2 !== 32'd4) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 00000004", res2); end
        last_result = 32'd4;
        $display("back_to_back: second result=%h done_cycle=%0d", res2, done2_cyc);
    endtask

    task automatic test_flush();
        int done_cnt;
        int bad_stall;
        done_cnt = 0; bad_stall = -1;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 10);
            #1;
            if (done === 1'b1) done_cnt++;
            if (c == 10) begin
                n_checks++;
                if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall_c10: got %b expected 1", stall); end
            end
            if (c >= 11 && stall !== 1'b0 && bad_stall < 0) bad_stall = c;
        end
        n_checks++;
        if (bad_stall >= 0) begin n_fail++; $display("FAIL flush_stall: stall high in cycle %0d expected low", bad_stall); end
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL flush_done: got %0d pulses expected 0", done_cnt); end
        n_checks++;
        if (result !== last_result) begin n_fail++; $display("FAIL flush_result: got %h expected %h", result, last_result); end
        $display("flush: done_pulses=%0d result=%h", done_cnt, result);
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; a = 32'd5; b = 32'd6;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) rst = 1'b0;
            if (c == 6) rst = 1'b1;
            #1;
            if (c == 5) begin
                n_checks++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
                n_checks++;
                if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
                n_checks++;
                if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 00000000", result); end
            end
            if (done === 1'b1) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt); end
        $display("reset_mid: done_pulses=%0d result=%h", done_cnt, result);
        do_op(3'd0, 32'd2, 32'd2, 32'd4, 33, "mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer for the execute stage. It accepts an M-extension operation (opcode op_b_reg, funct7 = 7'b0000001) from EX, runs a one-bit-per-cycle shift-add multiplier or restoring divider, and holds a stall to the pipeline until the 32-bit result is ready. Single-cycle ALU operations in EX are unaffected; this block owns the only multi-cycle arithmetic resource in the core.

## Interface
- WIDTH, 32: operand/result width; the iteration count equals WIDTH.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  EX request; sampled only in IDLE or DONE.
- funct3  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- a  in  WIDTH  rs1 value.
- b  in  WIDTH  rs2 value.
- flush  in  1  synchronous abort from branch/jump redirect.
- stall  out  1  freeze IF/ID/EX pipeline registers.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  rd value; held until next accepted start.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept: in IDLE or DONE with start=1 and flush=0. Latch funct3, the operand magnitudes, and the result sign. Clear the iteration counter.
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 goes to DIV, except for the special cases below.
- Signedness:
  - mul/mulh: both operands signed.
  - mulhsu: a signed, b unsigned.
  - mulhu/divu/remu: both unsigned.
  - div/rem: both signed.
- MUL: 2*WIDTH product register with shift-add on magnitudes, one multiplier bit per cycle.
  - After WIDTH iterations, negate the product if the signs differ.
  - mul returns the low WIDTH bits; mulh/mulhsu/mulhu return the high WIDTH bits.
- DIV: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases, decided at accept (next state DONE, no iterations):
  - Divide by zero: div/divu return all ones; rem/remu return a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, div/rem): div returns 0x80000000, rem returns 0.
- DONE: done=1 and result is loaded. Next state is IDLE, or MUL/DIV if a new start is accepted (back-to-back).
- start in MUL/DIV is ignored; EX holds start because the pipeline is stalled.
- flush in any state: next state is IDLE, done stays 0, result is unchanged. flush has priority over start.

## Timing
- Reset (rst=0, async): state=IDLE, counter=0, done=0, stall=0, result=0, product/quotient registers=0.
- stall = (start & state∈{IDLE,DONE} & ~flush) | (state∈{MUL,DIV}). It is combinational in the start cycle so EX holds. stall is low in DONE so the pipeline advances and captures result.
- Cycle numbering: cycle 0 is the cycle in which start is accepted (edge E0 at its end).
- MUL/DIV latency:
  - Iterations happen on edges E1..E_WIDTH.
  - The state is DONE after edge E_WIDTH; done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - stall is high in cycles 0..WIDTH.
- Special-case latency: done=1 in cycle 1; stall is high only in cycle 0.
- The counter saturates at WIDTH-1 and returns to 0 on accept.
- Reset mid-operation: outputs return to reset values immediately; no done.

## Test plan
- mul, a=7, b=0xFFFFFFFD: stall high cycles 0–32, done pulse in cycle 33, result=0xFFFFFFEB.
- High-half multiplies:
  - mulh 0x80000000*0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: div a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. rem with the same operands → 0xFFFFFFFF. divu 100/7 → 14; remu 100/7 → 2. Each has done in cycle 33.
- Divide by zero: divu 5/0 → 0xFFFFFFFF and rem 5/0 → 5. Overflow: div 0x80000000/0xFFFFFFFF → 0x80000000 and rem → 0. All with done in cycle 1.
- Back-to-back: mul 3*4, then start asserted during its DONE cycle with divu 9/2. First result 12 (done cycle 33); second result 4 (done cycle 66); no IDLE cycle between them.
- Abort and reset:
  - flush in cycle 10 of a div: stall low from cycle 11, no done, result unchanged.
  - rst=0 pulsed in cycle 5 of a mul: done=0, stall=0, result=0 immediately.
  - After release, mul 2*2 → 4.
